pll_lock_supervisor: RTL and testbench

Controls the system PLL's reset/locked interface from the free-running reference clock. Drives the PLL reset input and qualifies the PLL locked output. Generates the system reset that gates the 20 MHz domain, and re-arms the PLL on loss of lock. Counts relock events and flags a permanent fault after repeated lock-acquisition timeouts.

---
 rtl/pll_lock_supervisor.sv | 174 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the system PLL from the free-running reference clock: pulses the
// PLL reset, waits for a qualified lock, holds the PLL output domain in reset
// until lock has been stable long enough, and re-arms the PLL when lock is
// lost. Repeated acquisition timeouts end in a sticky fault.
//
// Ports:
//   refclk        in   reference clock, free-running, sole clock
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL locked output, asynchronous to refclk
//   pll_rst       out  PLL reset request, active high
//   sys_reset     out  reset for the PLL output domain, active high
//   lock_ok       out  high only while in RUN
//   relock_count  out  lock losses detected in RUN, saturating
//   retry_count   out  timeout retries taken in the current acquisition
//   fault         out  sticky lock-acquisition failure
//   state_dbg     out  current FSM state encoding (observability only)
//
// No valid/ready handshakes: pll_locked is a level, all outputs are levels.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 138000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             lock_ok,
    output logic [CNT_W-1:0] relock_count,
    output logic [2:0]       retry_count,
    output logic             fault,
    output logic [2:0]       state_dbg
);

    // The single cycle counter must reach the largest of the three terminal
    // counts minus one.
    localparam int CNT_M1  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_M1 > STABLE_CYCLES) ? CNT_M1 : STABLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);

    generate
        if (MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_bad_max_retries
            $error("MAX_RETRIES must be in 0..7 (retry_count is 3 bits)");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             lk;

    // Synchronizer for the asynchronous locked flag; the FSM sees only lk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // Next-state logic. The counter runs freely in every state and is cleared
    // whenever the state changes, so each state sees cnt starting at 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        retry_d  = retry_q;
        relock_d = relock_q;

        case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (lk) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = PLL_RESET;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            STABLE: begin
                // Any dropout restarts the lock wait without costing a retry.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = 3'd0;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = PLL_RESET;
                    if (relock_q != {CNT_W{1'b1}}) begin
                        relock_d = relock_q + CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with
    // state_q cycle for cycle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            retry_q   <= 3'd0;
            relock_q  <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            lock_ok   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst   <= (state_d == PLL_RESET) || (state_d == FAULT);
            sys_reset <= (state_d != RUN);
            lock_ok   <= (state_d == RUN);
            fault     <= (state_d == FAULT);
        end
    end

    assign relock_count = relock_q;
    assign retry_count  = retry_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with small parameters. Each task
// drives one scenario and checks its outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W         = 4;

    localparam logic [2:0] S_PLL_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             pll_rst;
    logic             sys_reset;
    logic             lock_ok;
    logic [CNT_W-1:0] relock_count;
    logic [2:0]       retry_count;
    logic             fault;
    logic [2:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int n;
    logic [CNT_W-1:0] exp_q[$];

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .SYNC_STAGES  (SYNC_STAGES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .lock_ok     (lock_ok),
        .relock_count(relock_count),
        .retry_count (retry_count),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 refclk = ~refclk;

    // Step one clock and land 1 ns after the edge for sampling/driving.
    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    // sys_reset must always be the complement of lock_ok.
    always @(negedge refclk) begin
        total++;
        if (sys_reset !== ~lock_ok) begin
            bad++;
            $display("FAIL invariant sys_reset=%0b lock_ok=%0b", sys_reset, lock_ok);
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        pll_locked = 1'b0;
        tick;
        tick;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%0b want=1", pll_rst); end
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL reset_sys_reset got=%0b want=1", sys_reset); end
        total++; if (lock_ok !== 1'b0) begin bad++; $display("FAIL reset_lock_ok got=%0b want=0", lock_ok); end
        total++; if (relock_count !== 4'd0) begin bad++; $display("FAIL reset_relock got=%0d want=0", relock_count); end
        total++; if (retry_count !== 3'd0) begin bad++; $display("FAIL reset_retry got=%0d want=0", retry_count); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", fault); end
        total++; if (state_dbg !== S_PLL_RESET) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, S_PLL_RESET); end
    endtask

    task automatic test_normal_lock;
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin tick; n++; end
        total++; if (n != 4) begin bad++; $display("FAIL normal_pll_rst_width got=%0d want=4", n); end
        total++; if (state_dbg !== S_WAIT_LOCK) begin bad++; $display("FAIL normal_wait_state got=%0d want=%0d", state_dbg, S_WAIT_LOCK); end
        tick;
        tick;
        pll_locked = 1'b1;
        n = 0;
        while (state_dbg !== S_STABLE && n < 50) begin tick; n++; end
        total++; if (n != 3) begin bad++; $display("FAIL normal_stable_latency got=%0d want=3", n); end
        n = 0;
        while (sys_reset === 1'b1 && n < 50) begin tick; n++; end
        total++; if (n != 8) begin bad++; $display("FAIL normal_stable_len got=%0d want=8", n); end
        total++; if (lock_ok !== 1'b1) begin bad++; $display("FAIL normal_lock_ok got=%0b want=1", lock_ok); end
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL normal_pll_rst got=%0b want=0", pll_rst); end
        total++; if (relock_count !== 4'd0) begin bad++; $display("FAIL normal_relock got=%0d want=0", relock_count); end
        total++; if (state_dbg !== S_RUN) begin bad++; $display("FAIL normal_run_state got=%0d want=%0d", state_dbg, S_RUN); end
    endtask

    task automatic test_loss_in_run;
        pll_locked = 1'b0;
        tick;
        tick;
        total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL loss_early_sys_reset got=%0b want=0", sys_reset); end
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL loss_early_pll_rst got=%0b want=0", pll_rst); end
        tick;
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL loss_sys_reset got=%0b want=1", sys_reset); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL loss_pll_rst got=%0b want=1", pll_rst); end
        total++; if (lock_ok !== 1'b0) begin bad++; $display("FAIL loss_lock_ok got=%0b want=0", lock_ok); end
        total++; if (relock_count !== 4'd1) begin bad++; $display("FAIL loss_relock got=%0d want=1", relock_count); end
        total++; if (state_dbg !== S_PLL_RESET) begin bad++; $display("FAIL loss_state got=%0d want=%0d", state_dbg, S_PLL_RESET); end
        pll_locked = 1'b1;
        n = 0;
        while (lock_ok !== 1'b1 && n < 60) begin tick; n++; end
        // 4 reset cycles + 1 wait cycle + 8 stable cycles
        total++; if (n != 13) begin bad++; $display("FAIL loss_relock_time got=%0d want=13", n); end
        total++; if (retry_count !== 3'd0) begin bad++; $display("FAIL loss_retry got=%0d want=0", retry_count); end
        total++; if (relock_count !== 4'd1) begin bad++; $display("FAIL loss_relock_after got=%0d want=1", relock_count); end
    endtask

    task automatic test_glitch;
        rst = 1'b1;
        pll_locked = 1'b0;
        tick;
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin tick; n++; end
        n = 0;
        while (pll_rst === 1'b0 && n < 50) begin tick; n++; end
        total++; if (n != 20) begin bad++; $display("FAIL glitch_timeout_len got=%0d want=20", n); end
        total++; if (retry_count !== 3'd1) begin bad++; $display("FAIL glitch_retry_pre got=%0d want=1", retry_count); end
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin tick; n++; end
        total++; if (n != 4) begin bad++; $display("FAIL glitch_retry_pulse got=%0d want=4", n); end
        pll_locked = 1'b1;
        n = 0;
        while (state_dbg !== S_STABLE && n < 50) begin tick; n++; end
        total++; if (n != 3) begin bad++; $display("FAIL glitch_stable_entry got=%0d want=3", n); end
        repeat (5) tick;
        // STABLE cnt=5: one-cycle dropout
        pll_locked = 1'b0;
        tick;
        pll_locked = 1'b1;
        tick;
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL glitch_no_release got=%0b want=1", sys_reset); end
        tick;
        total++; if (state_dbg !== S_WAIT_LOCK) begin bad++; $display("FAIL glitch_back_to_wait got=%0d want=%0d", state_dbg, S_WAIT_LOCK); end
        total++; if (retry_count !== 3'd1) begin bad++; $display("FAIL glitch_retry_kept got=%0d want=1", retry_count); end
        tick;
        total++; if (state_dbg !== S_STABLE) begin bad++; $display("FAIL glitch_restable got=%0d want=%0d", state_dbg, S_STABLE); end
        n = 0;
        while (sys_reset === 1'b1 && n < 50) begin tick; n++; end
        total++; if (n != 8) begin bad++; $display("FAIL glitch_stable_len got=%0d want=8", n); end
        total++; if (retry_count !== 3'd0) begin bad++; $display("FAIL glitch_retry_cleared got=%0d want=0", retry_count); end
    endtask

    task automatic test_timeouts;
        rst = 1'b1;
        pll_locked = 1'b0;
        tick;
        rst = 1'b0;
        for (int k = 0; k <= MAX_RETRIES; k++) begin
            total++; if (retry_count !== 3'(k)) begin bad++; $display("FAIL timeout_retry_%0d got=%0d want=%0d", k, retry_count, k); end
            n = 0;
            while (pll_rst === 1'b1 && n < 50) begin tick; n++; end
            total++; if (n != 4) begin bad++; $display("FAIL timeout_pulse_%0d got=%0d want=4", k, n); end
            n = 0;
            while (pll_rst === 1'b0 && n < 50) begin tick; n++; end
            total++; if (n != 20) begin bad++; $display("FAIL timeout_wait_%0d got=%0d want=20", k, n); end
        end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL timeout_fault got=%0b want=1", fault); end
        total++; if (state_dbg !== S_FAULT) begin bad++; $display("FAIL timeout_state got=%0d want=%0d", state_dbg, S_FAULT); end
        total++; if (retry_count !== 3'd2) begin bad++; $display("FAIL timeout_retry_final got=%0d want=2", retry_count); end
        pll_locked = 1'b1;
        repeat (10) tick;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%0b want=1", fault); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL fault_pll_rst got=%0b want=1", pll_rst); end
        total++; if (lock_ok !== 1'b0) begin bad++; $display("FAIL fault_lock_ok got=%0b want=0", lock_ok); end
    endtask

    task automatic test_reset_in_fault;
        rst = 1'b1;
        tick;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rstfault_fault got=%0b want=0", fault); end
        total++; if (retry_count !== 3'd0) begin bad++; $display("FAIL rstfault_retry got=%0d want=0", retry_count); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rstfault_pll_rst got=%0b want=1", pll_rst); end
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL rstfault_sys_reset got=%0b want=1", sys_reset); end
        total++; if (state_dbg !== S_PLL_RESET) begin bad++; $display("FAIL rstfault_state got=%0d want=%0d", state_dbg, S_PLL_RESET); end
    endtask

    task automatic test_saturation;
        logic [CNT_W-1:0] exp_cnt;
        logic [CNT_W-1:0] got_exp;
        rst = 1'b1;
        pll_locked = 1'b1;
        tick;
        rst = 1'b0;
        n = 0;
        while (lock_ok !== 1'b1 && n < 60) begin tick; n++; end
        total++; if (lock_ok !== 1'b1) begin bad++; $display("FAIL sat_initial_lock got=%0b want=1", lock_ok); end
        exp_cnt = '0;
        for (int i = 0; i < 17; i++) begin
            pll_locked = 1'b0;
            n = 0;
            while (lock_ok !== 1'b0 && n < 10) begin tick; n++; end
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            exp_q.push_back(exp_cnt);
            pll_locked = 1'b1;
            n = 0;
            while (lock_ok !== 1'b1 && n < 60) begin tick; n++; end
            total++; if (lock_ok !== 1'b1) begin bad++; $display("FAIL sat_relock_%0d got=%0b want=1", i, lock_ok); end
            got_exp = exp_q.pop_front();
            total++; if (relock_count !== got_exp) begin bad++; $display("FAIL sat_count_%0d got=%0d want=%0d", i, relock_count, got_exp); end
        end
        total++; if (relock_count !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", relock_count); end
    endtask

    task automatic test_reset_in_wait;
        pll_locked = 1'b0;
        n = 0;
        while (pll_rst === 1'b0 && n < 10) begin tick; n++; end
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin tick; n++; end
        n = 0;
        while (pll_rst === 1'b0 && n < 40) begin tick; n++; end
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin tick; n++; end
        tick;
        tick;
        total++; if (state_dbg !== S_WAIT_LOCK) begin bad++; $display("FAIL rstwait_pre_state got=%0d want=%0d", state_dbg, S_WAIT_LOCK); end
        total++; if (retry_count !== 3'd1) begin bad++; $display("FAIL rstwait_pre_retry got=%0d want=1", retry_count); end
        rst = 1'b1;
        tick;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rstwait_pll_rst got=%0b want=1", pll_rst); end
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL rstwait_sys_reset got=%0b want=1", sys_reset); end
        total++; if (lock_ok !== 1'b0) begin bad++; $display("FAIL rstwait_lock_ok got=%0b want=0", lock_ok); end
        total++; if (relock_count !== 4'd0) begin bad++; $display("FAIL rstwait_relock got=%0d want=0", relock_count); end
        total++; if (retry_count !== 3'd0) begin bad++; $display("FAIL rstwait_retry got=%0d want=0", retry_count); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rstwait_fault got=%0b want=0", fault); end
        total++; if (state_dbg !== S_PLL_RESET) begin bad++; $display("FAIL rstwait_state got=%0d want=%0d", state_dbg, S_PLL_RESET); end
        rst = 1'b0;
        tick;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset;
        test_normal_lock;
        test_loss_in_run;
        test_glitch;
        test_timeouts;
        test_reset_in_fault;
        test_saturation;
        test_reset_in_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
